// File: rtl/shader_tcache_pkg.sv
// rtl/shader_tcache_pkg.sv - shared types and coordinate resolve for shader_tcache_mc
package shader_tcache_pkg;

  typedef enum logic {
    ADDR_WRAP  = 1'b0,
    ADDR_CLAMP = 1'b1
  } addr_mode_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_DRAIN,
    DMA_WRITE
  } dma_state_t;

  // Maps a signed coordinate onto an axis 2**size texels wide.
  function automatic logic [31:0] resolve_coord(input logic signed [31:0] c,
                                                input addr_mode_t        mode,
                                                input int unsigned       size);
    logic signed [31:0] w;
    w = 32'sd1 <<< size;
    if (mode == ADDR_CLAMP) begin
      if (c < 0) return '0;
      if (c >= w) return w - 1;
      return c;
    end
    return c & (w - 1);
  endfunction

endpackage

// File: rtl/shader_tcache_port.sv
// rtl/shader_tcache_port.sv - one read channel: request reg (S1), output reg (S2), handshakes
module shader_tcache_port
  import shader_tcache_pkg::*;
#(
  parameter int TCACHE_SIZE = 3,
  parameter int TEXEL_BITS  = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       rd_en,
  input  logic                       rd_valid,
  output logic                       rd_ready,
  input  logic [TCACHE_SIZE+1:0]     rd_u,
  input  logic [TCACHE_SIZE+1:0]     rd_v,
  input  logic                       rd_mode,
  output logic                       s1_valid,
  output logic [2*TCACHE_SIZE-1:0]   s1_idx,
  input  logic [TEXEL_BITS-1:0]      lookup_texel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TEXEL_BITS-1:0]      out_texel
);

  localparam int IW = 2 * TCACHE_SIZE;

  logic                  s1_valid_q, s1_valid_d;
  logic [IW-1:0]         s1_idx_q, s1_idx_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [TEXEL_BITS-1:0] s2_texel_q, s2_texel_d;
  logic                  advance;
  logic [31:0]           u_res, v_res;
  logic [IW-1:0]         req_idx;

  always_comb begin
    u_res   = resolve_coord(32'($signed(rd_u)), addr_mode_t'(rd_mode), TCACHE_SIZE);
    v_res   = resolve_coord(32'($signed(rd_v)), addr_mode_t'(rd_mode), TCACHE_SIZE);
    req_idx = IW'(u_res + (v_res << TCACHE_SIZE));

    advance  = !s2_valid_q || out_ready;
    rd_ready = rd_en && (!s1_valid_q || advance);

    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    s2_valid_d = s2_valid_q;
    s2_texel_d = s2_texel_q;

    // The array is sampled only on the S1->S2 move, so S2 never sees a later DMA.
    if (advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_texel_d = lookup_texel;
      s1_valid_d = 1'b0;
    end
    if (rd_valid && rd_ready) begin
      s1_valid_d = 1'b1;
      s1_idx_d   = req_idx;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_texel_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      s2_texel_q <= s2_texel_d;
    end
  end

  assign s1_valid  = s1_valid_q;
  assign s1_idx    = s1_idx_q;
  assign out_valid = s2_valid_q;
  assign out_texel = s2_texel_q;

endmodule

// File: rtl/shader_tcache_mc.sv
// rtl/shader_tcache_mc.sv - multi-channel texture tile cache with coherent masked DMA refill
// Optional SHADER_TCACHE_STATS_EN builds the saturating read/DMA counters.
module shader_tcache_mc
  import shader_tcache_pkg::*;
#(
  parameter int                    TCACHE_SIZE = 3,
  parameter int                    TEXEL_BITS  = 4,
  parameter int                    CHANNELS    = 2,
  parameter logic [TEXEL_BITS-1:0] FILL_TEXEL  = '1
) (
  input  logic                                             aclk,
  input  logic                                             aresetn,
  input  logic                                             dma_valid,
  output logic                                             dma_ready,
  input  logic [(1<<(2*TCACHE_SIZE))*TEXEL_BITS-1:0]       dma_data,
  input  logic [(1<<(2*TCACHE_SIZE))-1:0]                  dma_mask,
  input  logic [CHANNELS-1:0]                              rd_valid,
  output logic [CHANNELS-1:0]                              rd_ready,
  input  logic [CHANNELS*(TCACHE_SIZE+2)-1:0]              rd_u,
  input  logic [CHANNELS*(TCACHE_SIZE+2)-1:0]              rd_v,
  input  logic [CHANNELS-1:0]                              rd_mode,
  output logic [CHANNELS-1:0]                              out_valid,
  input  logic [CHANNELS-1:0]                              out_ready,
  output logic [CHANNELS*TEXEL_BITS-1:0]                   out_texel,
  output logic [31:0]                                      stat_reads,
  output logic [15:0]                                      stat_dmas
);

  localparam int N  = 1 << (2 * TCACHE_SIZE);
  localparam int CW = TCACHE_SIZE + 2;
  localparam int IW = 2 * TCACHE_SIZE;

  dma_state_t            state_q, state_d;
  logic                  rd_en;
  logic                  dma_fire;
  logic [CHANNELS-1:0]   s1_valid;
  logic [IW-1:0]         s1_idx [CHANNELS];
  logic [TEXEL_BITS-1:0] lookup [CHANNELS];
  // Texels are stored XORed with FILL_TEXEL so the zeroed power-up array reads as FILL_TEXEL.
  logic [TEXEL_BITS-1:0] mem_q [N];
  logic [TEXEL_BITS-1:0] mem_d [N];

  assign rd_en = (state_q == DMA_IDLE);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_port
    assign lookup[ch] = mem_q[s1_idx[ch]] ^ FILL_TEXEL;

    shader_tcache_port #(
      .TCACHE_SIZE (TCACHE_SIZE),
      .TEXEL_BITS  (TEXEL_BITS)
    ) u_port (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .rd_en        (rd_en),
      .rd_valid     (rd_valid[ch]),
      .rd_ready     (rd_ready[ch]),
      .rd_u         (rd_u[ch*CW +: CW]),
      .rd_v         (rd_v[ch*CW +: CW]),
      .rd_mode      (rd_mode[ch]),
      .s1_valid     (s1_valid[ch]),
      .s1_idx       (s1_idx[ch]),
      .lookup_texel (lookup[ch]),
      .out_valid    (out_valid[ch]),
      .out_ready    (out_ready[ch]),
      .out_texel    (out_texel[ch*TEXEL_BITS +: TEXEL_BITS])
    );
  end

  always_comb begin
    state_d   = state_q;
    dma_ready = 1'b0;
    case (state_q)
      DMA_IDLE:  if (dma_valid) state_d = DMA_DRAIN;
      DMA_DRAIN: begin
        if (!dma_valid)          state_d = DMA_IDLE;
        else if (s1_valid == '0) state_d = DMA_WRITE;
      end
      DMA_WRITE: begin
        dma_ready = 1'b1;
        state_d   = DMA_IDLE;
      end
      default:   state_d = DMA_IDLE;
    endcase
  end

  assign dma_fire = dma_ready && dma_valid;

  always_comb begin
    mem_d = mem_q;
    if (dma_fire) begin
      for (int i = 0; i < N; i++) begin
        if (dma_mask[i]) mem_d[i] = dma_data[i*TEXEL_BITS +: TEXEL_BITS] ^ FILL_TEXEL;
      end
    end
  end

  always_ff @(posedge aclk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= DMA_IDLE;
    else          state_q <= state_d;
  end

`ifdef SHADER_TCACHE_STATS_EN
  logic [31:0] stat_reads_q, stat_reads_d;
  logic [15:0] stat_dmas_q, stat_dmas_d;
  logic [32:0] reads_sum;
  logic [3:0]  beats;

  always_comb begin
    beats = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      beats = beats + 4'(out_valid[ch] & out_ready[ch]);
    end
    reads_sum    = {1'b0, stat_reads_q} + 33'(beats);
    stat_reads_d = reads_sum[32] ? '1 : reads_sum[31:0];
    stat_dmas_d  = stat_dmas_q;
    if (dma_fire && (stat_dmas_q != '1)) stat_dmas_d = stat_dmas_q + 16'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_reads_q <= '0;
      stat_dmas_q  <= '0;
    end else begin
      stat_reads_q <= stat_reads_d;
      stat_dmas_q  <= stat_dmas_d;
    end
  end

  assign stat_reads = stat_reads_q;
  assign stat_dmas  = stat_dmas_q;
`else
  assign stat_reads = '0;
  assign stat_dmas  = '0;
`endif

endmodule

// File: tb/tb_shader_tcache_mc.sv
// tb/tb_shader_tcache_mc.sv - directed self-checking bench for shader_tcache_mc
module tb_shader_tcache_mc;

  localparam int TS = 3;
  localparam int TB = 4;
  localparam int CH = 2;
  localparam int N  = 64;
  localparam int CW = 5;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              dma_valid;
  logic              dma_ready;
  logic [N*TB-1:0]   dma_data;
  logic [N-1:0]      dma_mask;
  logic [CH-1:0]     rd_valid, rd_ready, rd_mode, out_valid, out_ready;
  logic [CH*CW-1:0]  rd_u, rd_v;
  logic [CH*TB-1:0]  out_texel;
  logic [31:0]       stat_reads;
  logic [15:0]       stat_dmas;

  int n_checks = 0;
  int n_errors = 0;

  shader_tcache_mc #(.TCACHE_SIZE(TS), .TEXEL_BITS(TB), .CHANNELS(CH)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .dma_valid  (dma_valid),
    .dma_ready  (dma_ready),
    .dma_data   (dma_data),
    .dma_mask   (dma_mask),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_u       (rd_u),
    .rd_v       (rd_v),
    .rd_mode    (rd_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_texel  (out_texel),
    .stat_reads (stat_reads),
    .stat_dmas  (stat_dmas)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [N*TB-1:0] tile_ramp();
    logic [N*TB-1:0] d;
    for (int i = 0; i < N; i++) d[i*TB +: TB] = TB'(i);
    return d;
  endfunction

  function automatic logic [N*TB-1:0] tile_const(input logic [TB-1:0] v);
    logic [N*TB-1:0] d;
    for (int i = 0; i < N; i++) d[i*TB +: TB] = v;
    return d;
  endfunction

  task automatic set_req(input int ch, input int u, input int v, input logic m);
    rd_u[ch*CW +: CW] = CW'(u);
    rd_v[ch*CW +: CW] = CW'(v);
    rd_mode[ch]       = m;
  endtask

  task automatic read_one(input int ch, input int u, input int v, input logic m,
                          input logic [TB-1:0] exp, input string tag);
    int guard;
    set_req(ch, u, v, m);
    rd_valid[ch] = 1'b1;
    guard = 0;
    while (!rd_ready[ch] && guard < 50) begin
      tick();
      guard++;
    end
    check_eq({tag, "_accept"}, 32'(rd_ready[ch]), 32'd1);
    tick();
    rd_valid[ch] = 1'b0;
    tick();
    check_eq({tag, "_valid"}, 32'(out_valid[ch]), 32'd1);
    check_eq(tag, 32'(out_texel[ch*TB +: TB]), 32'(exp));
    tick();
  endtask

  task automatic dma_xfer(input logic [N*TB-1:0] data, input logic [N-1:0] mask);
    int guard;
    dma_data  = data;
    dma_mask  = mask;
    dma_valid = 1'b1;
    guard = 0;
    while (!dma_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_eq("dma_handshake", 32'(dma_ready), 32'd1);
    tick();
    dma_valid = 1'b0;
  endtask

  int got [CH];
  int exp_idx;
  logic [31:0] reads_before;
  logic [31:0] exp_dmas3, exp_dmas4, exp_reads32;

  initial begin
`ifdef SHADER_TCACHE_STATS_EN
    exp_dmas3 = 32'd3; exp_dmas4 = 32'd4; exp_reads32 = 32'd32;
`else
    exp_dmas3 = 32'd0; exp_dmas4 = 32'd0; exp_reads32 = 32'd0;
`endif
    dma_valid = 1'b0; dma_data = '0; dma_mask = '0;
    rd_valid = '0; rd_mode = '0; rd_u = '0; rd_v = '0; out_ready = '1;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_texel", 32'(out_texel), 32'd0);
    check_eq("rst_dma_ready", 32'(dma_ready), 32'd0);
    check_eq("rst_stat_reads", stat_reads, 32'd0);
    check_eq("rst_stat_dmas", 32'(stat_dmas), 32'd0);
    aresetn = 1'b1;
    tick();

    read_one(0, 0, 0, 1'b0, 4'hF, "rd_fill");
    check_eq("stat_dmas_none", 32'(stat_dmas), 32'd0);

    dma_xfer(tile_ramp(), '1);
    read_one(0, 3, 1, 1'b0, 4'hB, "rd_wrap_3_1");
    read_one(1, -1, 0, 1'b0, 4'h7, "rd_wrap_neg");
    read_one(1, 9, -2, 1'b1, 4'h7, "rd_clamp_9_m2");
    read_one(0, 9, -2, 1'b0, 4'h1, "rd_wrap_9_m2");
    read_one(1, -16, 15, 1'b1, 4'h8, "rd_clamp_lo_hi");

    dma_xfer(tile_const(4'h5), 64'h1);
    read_one(0, 0, 0, 1'b0, 4'h5, "rd_mask_hit");
    read_one(0, 1, 0, 1'b0, 4'h1, "rd_mask_keep");
    dma_xfer(tile_const(4'h9), '0);
    read_one(0, 2, 0, 1'b0, 4'h2, "rd_zero_mask");
    check_eq("stat_dmas_3", 32'(stat_dmas), exp_dmas3);

    // Drain: S2 stalled holding texel 1, S1 holding texel 2 request.
    out_ready[0] = 1'b0;
    set_req(0, 1, 0, 1'b0);
    rd_valid[0] = 1'b1;
    tick();
    set_req(0, 2, 0, 1'b0);
    check_eq("drain_second_accept", 32'(rd_ready[0]), 32'd1);
    tick();
    rd_valid[0] = 1'b0;
    check_eq("drain_s2_valid", 32'(out_valid[0]), 32'd1);
    check_eq("drain_s2_texel", 32'(out_texel[3:0]), 32'h1);
    check_eq("drain_s1_blocks", 32'(rd_ready[0]), 32'd0);
    dma_data = tile_const(4'hA);
    dma_mask = '1;
    dma_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_hold_dma_ready", 32'(dma_ready), 32'd0);
      check_eq("drain_hold_rd_ready", 32'(rd_ready), 32'd0);
      tick();
    end
    out_ready[0] = 1'b1;
    check_eq("drain_rel_first", 32'(out_texel[3:0]), 32'h1);
    tick();
    check_eq("drain_old_valid", 32'(out_valid[0]), 32'd1);
    check_eq("drain_old_texel", 32'(out_texel[3:0]), 32'h2);
    check_eq("drain_not_yet", 32'(dma_ready), 32'd0);
    tick();
    check_eq("drain_dma_ready", 32'(dma_ready), 32'd1);
    tick();
    dma_valid = 1'b0;
    check_eq("drain_dma_done", 32'(dma_ready), 32'd0);
    read_one(0, 2, 0, 1'b0, 4'hA, "rd_post_drain");
    check_eq("stat_dmas_4", 32'(stat_dmas), exp_dmas4);

    // Throughput: both channels back to back.
    dma_xfer(tile_ramp(), '1);
    reads_before = stat_reads;
    got[0] = 0;
    got[1] = 0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc < 16) begin
        set_req(0, cyc % 8, cyc / 8, 1'b0);
        set_req(1, (63 - cyc) % 8, (63 - cyc) / 8, 1'b1);
        rd_valid = '1;
      end else begin
        rd_valid = '0;
      end
      for (int ch = 0; ch < CH; ch++) begin
        if (out_valid[ch]) begin
          exp_idx = (ch == 0) ? got[0] : 63 - got[1];
          check_eq("tput_texel", 32'(out_texel[ch*TB +: TB]), 32'(exp_idx % 16));
          got[ch]++;
        end
      end
      tick();
    end
    check_eq("tput_count_ch0", 32'(got[0]), 32'd16);
    check_eq("tput_count_ch1", 32'(got[1]), 32'd16);
    check_eq("tput_stat_reads", stat_reads - reads_before, exp_reads32);

    // Reset during DRAIN discards the tile.
    out_ready[0] = 1'b0;
    set_req(0, 3, 0, 1'b0);
    rd_valid[0] = 1'b1;
    tick();
    rd_valid[0] = 1'b0;
    tick();
    check_eq("rst_pre_valid", 32'(out_valid[0]), 32'd1);
    dma_data = tile_const(4'h0);
    dma_mask = '1;
    dma_valid = 1'b1;
    tick();
    check_eq("rst_in_drain", 32'(dma_ready), 32'd0);
    aresetn = 1'b0;
    #1;
    check_eq("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_dma_ready", 32'(dma_ready), 32'd0);
    check_eq("rst_mid_stat_reads", stat_reads, 32'd0);
    dma_valid = 1'b0;
    out_ready = '1;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    read_one(0, 5, 0, 1'b0, 4'h5, "rd_post_reset");
    read_one(1, 3, 0, 1'b1, 4'h3, "rd_post_reset_ch1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
